// File: rtl/copro_result_buffer.sv
// In-order result FIFO between the coprocessor ALU and the CV-X-IF result port.
// Provides a credit-based issue_ready_o so the no-backpressure ALU never loses a result.
module copro_result_buffer #(
  parameter int unsigned Depth       = 4,
  parameter int unsigned ResultWidth = 64,
  parameter type         hartid_t    = logic,
  parameter type         id_t        = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic                       valid_i,
  input  logic [ResultWidth-1:0]     result_i,
  input  hartid_t                    hartid_i,
  input  id_t                        id_i,
  input  logic [4:0]                 rd_i,
  input  logic                       we_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [ResultWidth-1:0]     result_data_o,
  output hartid_t                    result_hartid_o,
  output id_t                        result_id_o,
  output logic [4:0]                 result_rd_o,
  output logic                       result_we_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW:0]   DepthCmp = (CntW + 1)'(Depth);

  typedef struct packed {
    logic [ResultWidth-1:0] data;
    hartid_t                hartid;
    id_t                    id;
    logic [4:0]             rd;
    logic                   we;
  } entry_t;

  entry_t mem [Depth];

  logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CntW-1:0] count_reg, count_next;
  logic            inflight_reg, inflight_next;
  logic            overflow_reg, overflow_next;

  logic            full;
  logic            pop;
  logic            push;
  entry_t          wr_entry;
  entry_t          head;

  assign full = (count_reg == DepthCnt);
  assign pop  = (count_reg != '0) && result_ready_i;
  // A pop at full frees the slot this cycle, so the push still lands.
  assign push = valid_i && (!full || pop);

  always_comb begin
    wr_entry        = '0;
    wr_entry.data   = result_i;
    wr_entry.hartid = hartid_i;
    wr_entry.id     = id_i;
    wr_entry.rd     = rd_i;
    wr_entry.we     = we_i;
  end

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    inflight_next = issue_valid_i && issue_ready_o;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PtrW'(1);
    end
    count_next = count_reg + CntW'(push) - CntW'(pop);
    if (valid_i && !push) begin
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage needs no reset: entries are only observed while counted as valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  assign head            = mem[rd_ptr_reg];
  assign result_valid_o  = (count_reg != '0);
  assign result_data_o   = head.data;
  assign result_hartid_o = head.hartid;
  assign result_id_o     = head.id;
  assign result_rd_o     = head.rd;
  assign result_we_o     = head.we;
  assign count_o         = count_reg;
  assign overflow_o      = overflow_reg;

  // Conservative credit: ignores any same-cycle pop.
  assign issue_ready_o = (({1'b0, count_reg}) + (CntW + 1)'(inflight_reg)) < DepthCmp;

endmodule

// File: tb/tb_copro_result_buffer.sv
// Directed self-checking bench for copro_result_buffer (Depth 4, 8-bit ids).
module tb_copro_result_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic        valid_i;
  logic [63:0] result_i;
  logic [1:0]  hartid_i;
  logic [7:0]  id_i;
  logic [4:0]  rd_i;
  logic        we_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [63:0] result_data_o;
  logic [1:0]  result_hartid_o;
  logic [7:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic [2:0]  count_o;
  logic        overflow_o;

  int total = 0;
  int bad   = 0;

  copro_result_buffer #(
    .Depth(4),
    .ResultWidth(64),
    .hartid_t(logic [1:0]),
    .id_t(logic [7:0])
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i),
    .issue_ready_o(issue_ready_o),
    .valid_i(valid_i),
    .result_i(result_i),
    .hartid_i(hartid_i),
    .id_i(id_i),
    .rd_i(rd_i),
    .we_i(we_i),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .result_data_o(result_data_o),
    .result_hartid_o(result_hartid_o),
    .result_id_o(result_id_o),
    .result_rd_o(result_rd_o),
    .result_we_o(result_we_o),
    .count_o(count_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic push_id(input logic [7:0] id);
    valid_i  = 1'b1;
    id_i     = id;
    result_i = 64'(id) + 64'd100;
    rd_i     = id[4:0];
    we_i     = id[0];
    hartid_i = id[1:0];
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni         = 1'b0;
    issue_valid_i  = 1'b0;
    valid_i        = 1'b0;
    result_i       = '0;
    hartid_i       = '0;
    id_i           = '0;
    rd_i           = '0;
    we_i           = 1'b0;
    result_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b required 0", result_valid_o); end
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count got %0d required 0", count_o); end
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got %0b required 1", issue_ready_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_overflow got %0b required 0", overflow_o); end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_single_push;
    valid_i  = 1'b1;
    result_i = 64'h5;
    hartid_i = 2'd1;
    id_i     = 8'd3;
    rd_i     = 5'd7;
    we_i     = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    total++; if (result_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got %0b required 1", result_valid_o); end
    total++; if (result_data_o !== 64'h5) begin bad++; $display("FAIL single_data got %0h required 5", result_data_o); end
    total++; if (result_id_o !== 8'd3) begin bad++; $display("FAIL single_id got %0d required 3", result_id_o); end
    total++; if (result_rd_o !== 5'd7) begin bad++; $display("FAIL single_rd got %0d required 7", result_rd_o); end
    total++; if (result_we_o !== 1'b1) begin bad++; $display("FAIL single_we got %0b required 1", result_we_o); end
    total++; if (result_hartid_o !== 2'd1) begin bad++; $display("FAIL single_hartid got %0d required 1", result_hartid_o); end
    total++; if (count_o !== 3'd1) begin bad++; $display("FAIL single_count got %0d required 1", count_o); end
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL single_pop_count got %0d required 0", count_o); end
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL single_pop_valid got %0b required 0", result_valid_o); end
  endtask

  task automatic test_fill_drain;
    result_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_id(8'(i));
    total++; if (count_o !== 3'd4) begin bad++; $display("FAIL fill_count got %0d required 4", count_o); end
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL fill_issue_ready got %0b required 0", issue_ready_o); end
    for (int i = 0; i < 4; i++) begin
      total++; if (result_id_o !== 8'(i)) begin bad++; $display("FAIL drain_id got %0d required %0d", result_id_o, i); end
      total++; if (result_data_o !== 64'(i + 100)) begin bad++; $display("FAIL drain_data got %0d required %0d", result_data_o, i + 100); end
      result_ready_i = 1'b1;
      @(negedge clk_i);
    end
    result_ready_i = 1'b0;
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL drain_count got %0d required 0", count_o); end
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL drain_valid got %0b required 0", result_valid_o); end
  endtask

  task automatic test_full_simultaneous;
    logic [7:0] exp_ids [4];
    exp_ids = '{8'd1, 8'd2, 8'd3, 8'd9};
    for (int i = 0; i < 4; i++) push_id(8'(i));
    result_ready_i = 1'b1;
    push_id(8'd9);
    result_ready_i = 1'b0;
    total++; if (count_o !== 3'd4) begin bad++; $display("FAIL simul_count got %0d required 4", count_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL simul_overflow got %0b required 0", overflow_o); end
    for (int i = 0; i < 4; i++) begin
      total++; if (result_id_o !== exp_ids[i]) begin bad++; $display("FAIL simul_order got %0d required %0d", result_id_o, exp_ids[i]); end
      result_ready_i = 1'b1;
      @(negedge clk_i);
    end
    result_ready_i = 1'b0;
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL simul_drain_count got %0d required 0", count_o); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 4; i++) push_id(8'(10 + i));
    push_id(8'h55);
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_flag got %0b required 1", overflow_o); end
    total++; if (count_o !== 3'd4) begin bad++; $display("FAIL ovf_count got %0d required 4", count_o); end
    for (int i = 0; i < 4; i++) begin
      total++; if (result_id_o !== 8'(10 + i)) begin bad++; $display("FAIL ovf_order got %0d required %0d", result_id_o, 10 + i); end
      result_ready_i = 1'b1;
      @(negedge clk_i);
    end
    result_ready_i = 1'b0;
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %0b required 1", overflow_o); end
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL ovf_drain_count got %0d required 0", count_o); end
  endtask

  task automatic test_credit;
    issue_valid_i = 1'b1;
    @(negedge clk_i);
    issue_valid_i = 1'b0;
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL credit_empty got %0b required 1", issue_ready_o); end
    for (int i = 0; i < 3; i++) push_id(8'(20 + i));
    total++; if (count_o !== 3'd3) begin bad++; $display("FAIL credit_count3 got %0d required 3", count_o); end
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL credit_ready3 got %0b required 1", issue_ready_o); end
    issue_valid_i = 1'b1;
    @(negedge clk_i);
    issue_valid_i = 1'b0;
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL credit_inflight got %0b required 0", issue_ready_o); end
    // The issued op's result arrives now, together with a pop.
    result_ready_i = 1'b1;
    push_id(8'd23);
    result_ready_i = 1'b0;
    total++; if (count_o !== 3'd3) begin bad++; $display("FAIL credit_pushpop_count got %0d required 3", count_o); end
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL credit_reopen got %0b required 1", issue_ready_o); end
    total++; if (result_id_o !== 8'd21) begin bad++; $display("FAIL credit_head got %0d required 21", result_id_o); end
    result_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    result_ready_i = 1'b0;
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL credit_drain got %0d required 0", count_o); end
  endtask

  task automatic test_wrap_and_reset;
    logic [7:0] q [$];
    int pushed = 0;
    int popped = 0;
    int cnt    = 0;
    int cyc    = 0;
    bit do_push, do_pop;
    while (popped < 10 && cyc < 200) begin
      total++; if (count_o !== 3'(cnt)) begin bad++; $display("FAIL wrap_count cyc=%0d got %0d required %0d", cyc, count_o, cnt); end
      if (cnt > 0) begin
        total++; if (result_id_o !== q[0]) begin bad++; $display("FAIL wrap_order cyc=%0d got %0d required %0d", cyc, result_id_o, q[0]); end
      end
      do_pop  = (cyc % 4 != 1) && (cnt > 0);
      do_push = (cyc % 3 != 2) && (pushed < 10) && (cnt < 4);
      result_ready_i = (cyc % 4 != 1);
      valid_i        = do_push;
      id_i           = 8'(40 + pushed);
      result_i       = 64'(pushed);
      if (do_push) begin q.push_back(8'(40 + pushed)); pushed++; end
      if (do_pop) begin void'(q.pop_front()); popped++; end
      cnt = cnt + int'(do_push) - int'(do_pop);
      @(negedge clk_i);
      cyc++;
    end
    valid_i = 1'b0;
    result_ready_i = 1'b0;
    total++; if (popped != 10) begin bad++; $display("FAIL wrap_timeout got popped=%0d required 10", popped); end
    push_id(8'd60);
    push_id(8'd61);
    total++; if (count_o !== 3'd2) begin bad++; $display("FAIL rst_pre_count got %0d required 2", count_o); end
    #2 rst_ni = 1'b0;
    #1;
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL async_rst_valid got %0b required 0", result_valid_o); end
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL async_rst_count got %0d required 0", count_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL post_rst_valid got %0b required 0", result_valid_o); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_full_simultaneous();
    test_overflow();
    test_reset();
    test_credit();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/copro_result_buffer.md
Name: copro_result_buffer

Overview:
Result-side buffer placed directly downstream of the coprocessor ALU stage. It captures every valid ALU result (result, hartid, id, rd, we) into an in-order FIFO and presents the head entry on the CV-X-IF result interface using a valid/ready handshake. The ALU itself has no backpressure and one cycle of latency, so the block also generates a credit-based issue_ready_o. The issue stage uses it to stall, so that no result is ever lost while the core deasserts result_ready.

Parameters:
Depth, 4, number of FIFO entries; power of two, >= 2
ResultWidth, 64, width of the result data
hartid_t, logic, hart identifier type
id_t, logic, instruction identifier type

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
issue_valid_i  input  1  issue stage launches an instruction into the ALU this cycle
issue_ready_o  output  1  buffer guarantees space for a result issued this cycle
valid_i  input  1  ALU result valid
result_i  input  ResultWidth  ALU result data
hartid_i  input  hartid_t  ALU result hart id
id_i  input  id_t  ALU result instruction id
rd_i  input  5  ALU destination register
we_i  input  1  ALU register write enable
result_valid_o  output  1  head entry valid toward core
result_ready_i  input  1  core accepts head entry
result_data_o  output  ResultWidth  head result data
result_hartid_o  output  hartid_t  head hart id
result_id_o  output  id_t  head instruction id
result_rd_o  output  5  head destination register
result_we_o  output  1  head write enable
count_o  output  $clog2(Depth)+1  current occupancy
overflow_o  output  1  sticky error flag: a result was dropped

Behaviour:
- Reset (async, rst_ni low): wr/rd pointers = 0, count = 0, inflight_q = 0, overflow_o = 0. Therefore result_valid_o = 0, count_o = 0, issue_ready_o = 1. The other result_* outputs are don't-care while result_valid_o = 0. Reset mid-operation discards all entries and any in-flight credit immediately.
- Push: valid_i = 1 writes {result, hartid, id, rd, we} at wr_ptr on the rising edge. All valid results are stored, including NOP results (we = 0); the core still needs them to retire the id.
- Pop: result_valid_o && result_ready_i advances rd_ptr on the rising edge.
- result_valid_o = (count != 0). Outputs are driven combinationally from storage[rd_ptr]; head data is stable while valid and not ready.
- Latency: a result pushed into an empty buffer in cycle N appears on result_*_o in cycle N+1. There is no same-cycle bypass.
- Pointers are $clog2(Depth) bits and wrap naturally modulo Depth. count is tracked separately, range 0..Depth.
- Simultaneous push and pop: both happen and count is unchanged. This holds at count == Depth (the pop frees the slot in the same cycle) and at any other non-zero count. At count == 0 a pop is impossible, so only the push occurs.
- Credit scheme:
  - inflight_q <= issue_valid_i && issue_ready_o, which tracks the ALU's one-cycle latency.
  - issue_ready_o = (count + inflight_q) < Depth, combinational from registered state only.
  - The count term ignores any same-cycle pop, so the scheme is conservative.
- Overflow: valid_i = 1 while count == Depth and no pop in the same cycle. The result is dropped, storage and pointers are unchanged, and overflow_o is set. overflow_o stays set until reset. This is unreachable when the credit rule is obeyed.
- result_ready_i while result_valid_o = 0 has no effect.
- Output ordering is strictly the push order.

Test Plan:
- Reset then a single push (valid_i = 1, result = 64'h5, id = 3, rd = 7, we = 1) in cycle 0 -> cycle 1: result_valid_o = 1, data = 5, id = 3, rd = 7, we = 1, count_o = 1. After ready for one cycle -> count_o = 0 and valid = 0.
- Hold result_ready_i = 0 and push 4 results with ids 0..3 -> count_o = 4, issue_ready_o = 0. Then ready = 1 for 4 cycles -> ids emerge 0,1,2,3 and count_o returns to 0.
- Full buffer (count = 4) with simultaneous valid_i (id = 9) and ready -> id 0 pops, id 9 is stored, count stays 4, overflow_o = 0.
- Full buffer, valid_i = 1, ready = 0 -> entry dropped, overflow_o = 1 and stays 1. The next pops show the original 4 ids, not the dropped one.
- Credit: count = 3, issue_valid_i = 1 with issue_ready_o = 1 -> next cycle inflight = 1 and issue_ready_o = 0. A pop in that cycle reopens issue_ready_o the cycle after.
- Wrap and reset: push/pop 10 entries through Depth = 4 with interleaved stalls -> in-order delivery across pointer wrap. Assert rst_ni low with count = 2 -> result_valid_o = 0 and count_o = 0 immediately (asynchronously).
